msrv32_integer_file: RTL and testbench

- 32-entry x 32-bit integer register file for the MSRV32 core. Sits directly downstream of msrv32_wr_en_generator.
- Its write port consumes wr_en_integer_file_out. Write address and data come from the stage-3 pipeline register and the writeback mux.
- Two combinational read ports feed the decode/operand stage.
- Write-through bypass: a same-cycle write to a register being read is visible immediately. Register x0 is hardwired to zero.

---
 rtl/msrv32_integer_file.sv | 59 +++++
 tb/tb_msrv32_integer_file.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/msrv32_integer_file.sv
// MSRV32 integer register file: 31 writable 32-bit registers plus hardwired x0,
// two combinational read ports with same-cycle write-through bypass.
module msrv32_integer_file #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              wr_en_in,
  input  logic [XLEN-1:0]   rd_in,
  output logic [XLEN-1:0]   rs_1_out,
  output logic [XLEN-1:0]   rs_2_out
);

  localparam int NREG = 2 ** ADDR_W;

  // x0 has no storage; entries start at 1
  logic [XLEN-1:0] reg_file [1:NREG-1];

  logic commit;
  assign commit = !ms_riscv32_mp_rst_in && wr_en_in;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 1; i < NREG; i++) begin
        reg_file[i] <= '0;
      end
    end else if (wr_en_in && (rd_addr_in != '0)) begin
      reg_file[rd_addr_in] <= rd_in;
    end
  end

  // Bypass only when the write will actually commit on this edge
  always_comb begin
    rs_1_out = '0;
    if (rs_1_addr_in == '0) begin
      rs_1_out = '0;
    end else if (commit && (rs_1_addr_in == rd_addr_in)) begin
      rs_1_out = rd_in;
    end else begin
      rs_1_out = reg_file[rs_1_addr_in];
    end
  end

  always_comb begin
    rs_2_out = '0;
    if (rs_2_addr_in == '0) begin
      rs_2_out = '0;
    end else if (commit && (rs_2_addr_in == rd_addr_in)) begin
      rs_2_out = rd_in;
    end else begin
      rs_2_out = reg_file[rs_2_addr_in];
    end
  end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Table-driven bench for msrv32_integer_file with an expected-value scoreboard.
module tb_msrv32_integer_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_1_addr, rs_2_addr, rd_addr;
  logic        wr_en;
  logic [31:0] rd_data;
  logic [31:0] rs_1_out, rs_2_out;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  msrv32_integer_file #(.XLEN(32), .ADDR_W(5)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .rs_1_addr_in(rs_1_addr),
    .rs_2_addr_in(rs_2_addr),
    .rd_addr_in(rd_addr),
    .wr_en_in(wr_en),
    .rd_in(rd_data),
    .rs_1_out(rs_1_out),
    .rs_2_out(rs_2_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: timeout reached, run did not complete");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(input logic r, input logic we, input logic [4:0] rd,
                              input logic [31:0] data, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [31:0] e1,
                              input logic [31:0] e2, input string name);
    vec_t v;
    v.rst = r; v.we = we; v.rd = rd; v.data = data;
    v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.name = name;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rst       = v.rst;
    wr_en     = v.we;
    rd_addr   = v.rd;
    rd_data   = v.data;
    rs_1_addr = v.a1;
    rs_2_addr = v.a2;
    e.e1 = v.e1; e.e2 = v.e2; e.name = v.name;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: nothing expected for this output");
      return;
    end
    e = sb_q.pop_front();
    tests_run++;
    if (rs_1_out !== e.e1) begin
      tests_failed++;
      $display("[TB] FAIL %s rs_1_out: got %h expected %h", e.name, rs_1_out, e.e1);
    end
    tests_run++;
    if (rs_2_out !== e.e2) begin
      tests_failed++;
      $display("[TB] FAIL %s rs_2_out: got %h expected %h", e.name, rs_2_out, e.e2);
    end
  endtask

  // Drive on the falling edge, check combinational outputs before the rising edge
  task automatic runVec(input vec_t v);
    applyStimulus(v);
    #1;
    checkOutput();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pat;
    logic [4:0]  a2;

    pat = 32'h01010101;

    tbl.push_back(mk(1, 0, 0, 32'h0,        5,  0,  32'h0,        32'h0,        "reset_hold"));
    tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 5,  6,  32'hDEADBEEF, 32'h0,        "wr_x5_bypass"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF, "x5_stored"));
    tbl.push_back(mk(1, 0, 0, 32'h0,        5,  0,  32'hDEADBEEF, 32'h0,        "rst_pre_edge"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        5,  5,  32'h0,        32'h0,        "x5_cleared"));
    tbl.push_back(mk(0, 1, 10, 32'h12345678, 11, 0, 32'h0,        32'h0,        "wr_x10"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        10, 10, 32'h12345678, 32'h12345678, "x10_both"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        11, 10, 32'h0,        32'h12345678, "x11_zero"));
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0,  0,  32'h0,        32'h0,        "x0_write"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0,  10, 32'h0,        32'h12345678, "x0_after"));
    tbl.push_back(mk(0, 1, 7, 32'h11111111, 0,  0,  32'h0,        32'h0,        "wr_x7"));
    tbl.push_back(mk(0, 1, 7, 32'h22222222, 7,  7,  32'h22222222, 32'h22222222, "bypass_x7"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        7,  7,  32'h22222222, 32'h22222222, "x7_retained"));
    tbl.push_back(mk(0, 0, 3, 32'hAAAA5555, 3,  3,  32'h0,        32'h0,        "wr_dis_x3"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        3,  7,  32'h0,        32'h22222222, "x3_unchanged"));
    tbl.push_back(mk(1, 1, 3, 32'h5A5A5A5A, 3,  7,  32'h0,        32'h22222222, "rst_prio"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        3,  7,  32'h0,        32'h0,        "after_rst_prio"));
    tbl.push_back(mk(0, 1, 9, 32'h0000AAAA, 9,  0,  32'h0000AAAA, 32'h0,        "b2b_first"));
    tbl.push_back(mk(0, 1, 9, 32'h0000BBBB, 9,  9,  32'h0000BBBB, 32'h0000BBBB, "b2b_second"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        9,  9,  32'h0000BBBB, 32'h0000BBBB, "b2b_final"));
    tbl.push_back(mk(0, 1, 12, 32'h0C0C0C0C, 9, 12, 32'h0000BBBB, 32'h0C0C0C0C, "bypass_p2"));
    tbl.push_back(mk(1, 0, 0, 32'h0,        12, 9,  32'h0C0C0C0C, 32'h0000BBBB, "rst_pre_edge2"));
    tbl.push_back(mk(0, 0, 0, 32'h0,        12, 9,  32'h0,        32'h0,        "rst_cleared2"));

    rst = 1'b1; wr_en = 1'b0; rd_addr = '0; rd_data = '0;
    rs_1_addr = '0; rs_2_addr = '0;
    @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) runVec(tbl[i]);

    // Sweep: write x1..x31 (port 1 sees the bypassed value), then read pairs (a, 32-a)
    for (int a = 1; a < 32; a++) begin
      runVec(mk(0, 1, 5'(a), pat * 32'(a), 5'(a), 0, pat * 32'(a), 32'h0, "sweep_wr"));
    end
    for (int a = 0; a < 32; a++) begin
      a2 = 5'((32 - a) % 32);
      runVec(mk(0, 0, 0, 32'h0, 5'(a), a2,
                (a == 0) ? 32'h0 : pat * 32'(a),
                (a2 == 0) ? 32'h0 : pat * 32'(a2), "sweep_rd"));
    end

    // One-cycle reset then every register must read zero
    runVec(mk(1, 0, 0, 32'h0, 31, 1, 32'h1F1F1F1F, 32'h01010101, "sweep_rst"));
    for (int a = 0; a < 32; a++) begin
      runVec(mk(0, 0, 0, 32'h0, 5'(a), 5'((a + 16) % 32), 32'h0, 32'h0, "all_zero"));
    end

    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
